// File: rtl/proc_fetch.sv
// Instruction fetch stage: issues in-order word fetches from the current PC, buffers the returned
// words in a small circular queue for decode, and drives the PC register's load strobe.
module proc_fetch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output logic                  o_ld_pc,
  output logic [DATA_WIDTH-1:0] o_next_pc,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_gnt,
  input  logic                  i_imem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic                  o_if_valid,
  output logic [DATA_WIDTH-1:0] o_if_instr,
  output logic [DATA_WIDTH-1:0] o_if_pc,
  input  logic                  i_if_ready,
  input  logic                  i_redirect,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  output logic                  o_misalign
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  // Stale responses can pile up across back-to-back redirects, so the drop counter is wider.
  localparam int unsigned DropW = CntW + 4;
  localparam int unsigned DSumW = DropW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] pc_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] pc_d    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] filled_q, filled_d;
  logic [PtrW-1:0]       alloc_ptr_q, alloc_ptr_d;
  logic [PtrW-1:0]       fill_ptr_q, fill_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       alloc_cnt_q, alloc_cnt_d;
  logic [CntW-1:0]       unfill_cnt_q, unfill_cnt_d;
  logic [DropW-1:0]      drop_cnt_q, drop_cnt_d;
  logic                  misalign_q, misalign_d;

  logic             accept, fill, drop, deq;
  logic [DSumW-1:0] drop_sum;

  assign o_imem_req = rst_n & ~i_redirect & ~misalign_q & (i_pc[1:0] == 2'b00) &
                      (alloc_cnt_q < DepthCnt);
  assign accept     = o_imem_req & i_imem_gnt;
  assign o_imem_addr = i_pc;
  assign o_ld_pc    = rst_n & (accept | i_redirect);
  assign o_next_pc  = i_redirect ? i_redirect_pc :
                      accept     ? i_pc + DATA_WIDTH'(32'd4) : i_pc;

  assign o_if_valid = filled_q[rd_ptr_q] & ~i_redirect;
  assign o_if_instr = instr_q[rd_ptr_q];
  assign o_if_pc    = pc_q[rd_ptr_q];
  assign o_misalign = misalign_q;

  assign deq  = o_if_valid & i_if_ready;
  assign drop = i_imem_rvalid & ~i_redirect & (drop_cnt_q != '0);
  assign fill = i_imem_rvalid & ~i_redirect & (drop_cnt_q == '0) & (unfill_cnt_q != '0);

  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    filled_d     = filled_q;
    alloc_ptr_d  = alloc_ptr_q;
    fill_ptr_d   = fill_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    alloc_cnt_d  = alloc_cnt_q;
    unfill_cnt_d = unfill_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    misalign_d   = misalign_q;
    drop_sum     = {1'b0, drop_cnt_q} + DSumW'(unfill_cnt_q);

    if (i_redirect) begin
      // Every in-flight fetch becomes a stale response; one may be retiring right now.
      if (i_imem_rvalid && drop_sum != '0) drop_sum = drop_sum - DSumW'(1);
      drop_cnt_d   = drop_sum[DSumW-1] ? '1 : drop_sum[DropW-1:0];
      filled_d     = '0;
      alloc_ptr_d  = '0;
      fill_ptr_d   = '0;
      rd_ptr_d     = '0;
      alloc_cnt_d  = '0;
      unfill_cnt_d = '0;
      misalign_d   = 1'b0;
    end else begin
      if (accept) begin
        pc_d[alloc_ptr_q]     = i_pc;
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + PtrW'(1);
      end
      if (fill) begin
        instr_d[fill_ptr_q]  = i_imem_rdata;
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PtrW'(1);
      end
      if (drop) drop_cnt_d = drop_cnt_q - DropW'(1);
      if (deq) begin
        filled_d[rd_ptr_q] = 1'b0;
        rd_ptr_d           = rd_ptr_q + PtrW'(1);
      end
      alloc_cnt_d  = alloc_cnt_q + CntW'(accept) - CntW'(deq);
      unfill_cnt_d = unfill_cnt_q + CntW'(accept) - CntW'(fill);
      if (i_pc[1:0] != 2'b00) misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= '{default: '0};
      instr_q      <= '{default: '0};
      filled_q     <= '0;
      alloc_ptr_q  <= '0;
      fill_ptr_q   <= '0;
      rd_ptr_q     <= '0;
      alloc_cnt_q  <= '0;
      unfill_cnt_q <= '0;
      drop_cnt_q   <= '0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      filled_q     <= filled_d;
      alloc_ptr_q  <= alloc_ptr_d;
      fill_ptr_q   <= fill_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      alloc_cnt_q  <= alloc_cnt_d;
      unfill_cnt_q <= unfill_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      misalign_q   <= misalign_d;
    end
  end

endmodule

// File: tb/tb_proc_fetch.sv
// Directed bench for proc_fetch with a PC register and an in-order 1-cycle instruction memory
// whose word at address A is A + 0x1000_0000.
module tb_proc_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] i_pc;
  logic        o_ld_pc;
  logic [31:0] o_next_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_if_valid;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
  logic        i_if_ready = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_misalign;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_reg, pc_reset = 32'd128, pc_force = '0;
  logic        force_en = 1'b0;
  logic        mem_en = 1'b1;
  logic [31:0] mq[$];
  bit          ok;

  proc_fetch #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_pc(i_pc), .o_ld_pc(o_ld_pc), .o_next_pc(o_next_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata), .o_if_valid(o_if_valid),
    .o_if_instr(o_if_instr), .o_if_pc(o_if_pc), .i_if_ready(i_if_ready),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .o_misalign(o_misalign)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_reg <= pc_reset;
    else if (o_ld_pc) pc_reg <= o_next_pc;
  end
  assign i_pc = force_en ? pc_force : pc_reg;

  always @(posedge clk) if (rst_n && o_imem_req && i_imem_gnt) mq.push_back(o_imem_addr);

  always @(negedge clk) begin
    if (rst_n && mem_en && mq.size() > 0) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mq.pop_front() + 32'h1000_0000;
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cyc();
      if (o_if_valid === 1'b1) found = 1'b1;
    end
  endtask

  task automatic do_reset(input logic [31:0] rpc);
    @(negedge clk);
    i_imem_gnt = 1'b0; i_if_ready = 1'b0; i_redirect = 1'b0; force_en = 1'b0; mem_en = 1'b1;
    pc_reset = rpc;
    rst_n = 1'b0;
    #1 mq.delete();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pc_reset = 32'd128; i_imem_gnt = 1'b1; i_if_ready = 1'b1; mem_en = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) cyc();
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", o_imem_req); end
    checks++; if (o_ld_pc !== 1'b0) begin errors++; $display("FAIL rst_ld_pc: got %b want 0", o_ld_pc); end
    checks++; if (o_if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_if_valid); end
    checks++; if (o_misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b want 0", o_misalign); end
    rst_n = 1'b1;
    #1;
    checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL rel_req: got %b want 1", o_imem_req); end
    checks++; if (o_imem_addr !== 32'd128) begin errors++; $display("FAIL rel_addr: got %h want %h", o_imem_addr, 32'd128); end
    checks++; if (o_ld_pc !== 1'b1) begin errors++; $display("FAIL rel_ld_pc: got %b want 1", o_ld_pc); end
    checks++; if (o_next_pc !== 32'd132) begin errors++; $display("FAIL rel_next_pc: got %h want %h", o_next_pc, 32'd132); end
  endtask

  // Continues straight on from test_reset with gnt=1 and ready=1.
  task automatic test_streaming();
    cyc();
    checks++; if (o_if_valid !== 1'b0 || o_imem_addr !== 32'h84) begin errors++;
      $display("FAIL stream_c1: valid=%b addr=%h want valid=0 addr=00000084", o_if_valid, o_imem_addr); end
    cyc();
    checks++; if (o_if_valid !== 1'b1 || o_if_pc !== 32'h80 || o_if_instr !== 32'h1000_0080) begin errors++;
      $display("FAIL stream_128: valid=%b pc=%h instr=%h want 1 00000080 10000080", o_if_valid, o_if_pc, o_if_instr); end
    cyc();
    checks++; if (o_if_valid !== 1'b1 || o_if_pc !== 32'h84 || o_if_instr !== 32'h1000_0084) begin errors++;
      $display("FAIL stream_132: valid=%b pc=%h instr=%h want 1 00000084 10000084", o_if_valid, o_if_pc, o_if_instr); end
    wait_valid(ok);
    checks++; if (!ok || o_if_pc !== 32'h88 || o_if_instr !== 32'h1000_0088) begin errors++;
      $display("FAIL stream_136: seen=%b pc=%h instr=%h want 00000088 10000088", ok, o_if_pc, o_if_instr); end
    wait_valid(ok);
    checks++; if (!ok || o_if_pc !== 32'h8C || o_if_instr !== 32'h1000_008C) begin errors++;
      $display("FAIL stream_140: seen=%b pc=%h instr=%h want 0000008c 1000008c", ok, o_if_pc, o_if_instr); end
  endtask

  task automatic test_backpressure();
    do_reset(32'd128);
    i_imem_gnt = 1'b1;
    #1;
    checks++; if (o_ld_pc !== 1'b1 || o_next_pc !== 32'h84) begin errors++;
      $display("FAIL bp_grant0: ld=%b next=%h want 1 00000084", o_ld_pc, o_next_pc); end
    cyc();
    checks++; if (o_ld_pc !== 1'b1 || o_next_pc !== 32'h88) begin errors++;
      $display("FAIL bp_grant1: ld=%b next=%h want 1 00000088", o_ld_pc, o_next_pc); end
    cyc();
    checks++; if (o_imem_req !== 1'b0 || o_ld_pc !== 1'b0) begin errors++;
      $display("FAIL bp_full: req=%b ld=%b want 0 0", o_imem_req, o_ld_pc); end
    repeat (3) cyc();
    checks++; if (o_imem_req !== 1'b0 || o_if_valid !== 1'b1 || o_if_pc !== 32'h80 || o_if_instr !== 32'h1000_0080) begin
      errors++; $display("FAIL bp_hold: req=%b valid=%b pc=%h instr=%h want 0 1 00000080 10000080",
                         o_imem_req, o_if_valid, o_if_pc, o_if_instr); end
    i_if_ready = 1'b1;
    #1;
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL bp_same_cycle_req: got %b want 0", o_imem_req); end
    cyc();
    checks++; if (o_if_valid !== 1'b1 || o_if_pc !== 32'h84 || o_if_instr !== 32'h1000_0084) begin errors++;
      $display("FAIL bp_second: valid=%b pc=%h instr=%h want 1 00000084 10000084", o_if_valid, o_if_pc, o_if_instr); end
    checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h88) begin errors++;
      $display("FAIL bp_resume: req=%b addr=%h want 1 00000088", o_imem_req, o_imem_addr); end
    wait_valid(ok);
    checks++; if (!ok || o_if_pc !== 32'h88 || o_if_instr !== 32'h1000_0088) begin errors++;
      $display("FAIL bp_136: seen=%b pc=%h instr=%h want 00000088 10000088", ok, o_if_pc, o_if_instr); end
  endtask

  task automatic test_redirect();
    do_reset(32'd128);
    mem_en = 1'b0; i_imem_gnt = 1'b1; i_if_ready = 1'b1;
    repeat (2) cyc();
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rd_full_req: got %b want 0", o_imem_req); end
    i_redirect = 1'b1; i_redirect_pc = 32'h200;
    #1;
    checks++; if (o_ld_pc !== 1'b1 || o_next_pc !== 32'h200 || o_if_valid !== 1'b0) begin errors++;
      $display("FAIL rd_cycle: ld=%b next=%h valid=%b want 1 00000200 0", o_ld_pc, o_next_pc, o_if_valid); end
    cyc();
    i_redirect = 1'b0; mem_en = 1'b1;
    #1;
    checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h200) begin errors++;
      $display("FAIL rd_req: req=%b addr=%h want 1 00000200", o_imem_req, o_imem_addr); end
    wait_valid(ok);
    checks++; if (!ok || o_if_pc !== 32'h200 || o_if_instr !== 32'h1000_0200) begin errors++;
      $display("FAIL rd_first: seen=%b pc=%h instr=%h want 00000200 10000200", ok, o_if_pc, o_if_instr); end
    wait_valid(ok);
    checks++; if (!ok || o_if_pc !== 32'h204 || o_if_instr !== 32'h1000_0204) begin errors++;
      $display("FAIL rd_second: seen=%b pc=%h instr=%h want 00000204 10000204", ok, o_if_pc, o_if_instr); end
  endtask

  task automatic test_wrap_redirect();
    do_reset(32'hFFFF_FFFC);
    i_imem_gnt = 1'b1;
    #1;
    checks++; if (o_ld_pc !== 1'b1 || o_next_pc !== 32'h0) begin errors++;
      $display("FAIL wrap_next: ld=%b next=%h want 1 00000000", o_ld_pc, o_next_pc); end
    cyc();
    checks++; if (o_imem_addr !== 32'h0 || o_next_pc !== 32'h4) begin errors++;
      $display("FAIL wrap_addr: addr=%h next=%h want 00000000 00000004", o_imem_addr, o_next_pc); end
    cyc();
    checks++; if (o_if_valid !== 1'b1 || o_if_pc !== 32'hFFFF_FFFC || o_if_instr !== 32'h0FFF_FFFC) begin errors++;
      $display("FAIL wrap_head: valid=%b pc=%h instr=%h want 1 fffffffc 0ffffffc", o_if_valid, o_if_pc, o_if_instr); end
    i_redirect = 1'b1; i_redirect_pc = 32'h400;
    #1;
    checks++; if (o_if_valid !== 1'b0 || o_ld_pc !== 1'b1 || o_next_pc !== 32'h400 || o_imem_req !== 1'b0) begin
      errors++; $display("FAIL wrap_redirect: valid=%b ld=%b next=%h req=%b want 0 1 00000400 0",
                         o_if_valid, o_ld_pc, o_next_pc, o_imem_req); end
    cyc();
    i_redirect = 1'b0; i_if_ready = 1'b1;
    #1;
    checks++; if (o_if_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h400) begin errors++;
      $display("FAIL wrap_after: valid=%b req=%b addr=%h want 0 1 00000400", o_if_valid, o_imem_req, o_imem_addr); end
    wait_valid(ok);
    checks++; if (!ok || o_if_pc !== 32'h400 || o_if_instr !== 32'h1000_0400) begin errors++;
      $display("FAIL wrap_target: seen=%b pc=%h instr=%h want 00000400 10000400", ok, o_if_pc, o_if_instr); end
  endtask

  task automatic test_misalign();
    do_reset(32'd128);
    i_imem_gnt = 1'b1;
    cyc();
    i_imem_gnt = 1'b0; force_en = 1'b1; pc_force = 32'h136;
    #1;
    checks++; if (o_imem_req !== 1'b0 || o_misalign !== 1'b0) begin errors++;
      $display("FAIL mis_detect: req=%b misalign=%b want 0 0", o_imem_req, o_misalign); end
    cyc();
    checks++; if (o_misalign !== 1'b1 || o_if_valid !== 1'b1 || o_if_pc !== 32'h80) begin errors++;
      $display("FAIL mis_set: misalign=%b valid=%b pc=%h want 1 1 00000080", o_misalign, o_if_valid, o_if_pc); end
    force_en = 1'b0; i_imem_gnt = 1'b1; i_if_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if (o_misalign !== 1'b1 || o_imem_req !== 1'b0 || o_ld_pc !== 1'b0) begin errors++;
        $display("FAIL mis_sticky%0d: misalign=%b req=%b ld=%b want 1 0 0", i, o_misalign, o_imem_req, o_ld_pc); end
    end
    checks++; if (o_if_valid !== 1'b0) begin errors++; $display("FAIL mis_drain: valid=%b want 0", o_if_valid); end
    i_redirect = 1'b1; i_redirect_pc = 32'h202;
    #1;
    checks++; if (o_ld_pc !== 1'b1 || o_next_pc !== 32'h202) begin errors++;
      $display("FAIL mis_rd202: ld=%b next=%h want 1 00000202", o_ld_pc, o_next_pc); end
    cyc();
    i_redirect = 1'b0;
    #1;
    checks++; if (o_misalign !== 1'b0 || o_imem_req !== 1'b0) begin errors++;
      $display("FAIL mis_202_first: misalign=%b req=%b want 0 0", o_misalign, o_imem_req); end
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if (o_misalign !== 1'b1 || o_imem_req !== 1'b0 || o_ld_pc !== 1'b0) begin errors++;
        $display("FAIL mis_202_%0d: misalign=%b req=%b ld=%b want 1 0 0", i, o_misalign, o_imem_req, o_ld_pc); end
    end
    i_redirect = 1'b1; i_redirect_pc = 32'h300;
    #1;
    checks++; if (o_ld_pc !== 1'b1 || o_next_pc !== 32'h300 || o_imem_req !== 1'b0) begin errors++;
      $display("FAIL mis_rd300: ld=%b next=%h req=%b want 1 00000300 0", o_ld_pc, o_next_pc, o_imem_req); end
    cyc();
    i_redirect = 1'b0;
    #1;
    checks++; if (o_misalign !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h300) begin errors++;
      $display("FAIL mis_clear: misalign=%b req=%b addr=%h want 0 1 00000300", o_misalign, o_imem_req, o_imem_addr); end
    wait_valid(ok);
    checks++; if (!ok || o_if_pc !== 32'h300 || o_if_instr !== 32'h1000_0300) begin errors++;
      $display("FAIL mis_fetch300: seen=%b pc=%h instr=%h want 00000300 10000300", ok, o_if_pc, o_if_instr); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_wrap_redirect();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
